// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//
// Reaction-time game core. A start press arms a pseudo-random delay. When the
// delay expires the GO LED lights and an N-digit BCD tenths counter runs until
// the stop button is pressed. A stop press during the delay is a foul and shows
// dashes on every digit. The score is shown on a time-multiplexed seven-segment
// display.
//
// Handshake: there are no valid/ready channels. Both buttons are level inputs,
// already synchronised to clk. Only a rise, meaning the input is high while its
// registered copy is low, is acted on. The rise and the resulting state change
// happen on the same posedge.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   start    in   start button (level)
//   stop     in   stop button (level)
//   seg      out  segments {g,f,e,d,c,b,a}, active-high, registered
//   dig_idx  out  index of the digit currently shown on seg (0 = ones)
//   led_go   out  high only while in PLAY
//   state    out  FSM state: 0=IDLE, 1=WAIT, 2=PLAY, 3=FINISH
//   score    out  BCD digit registers, digit 0 in [3:0]
// -----------------------------------------------------------------------------
module reaction_timer #(
    parameter int DIGITS     = 2,
    parameter int TICK_DIV   = 2_000_000,
    parameter int MUX_DIV    = 4,
    parameter int DELAY_MIN  = 10,
    parameter int DELAY_BITS = 5,
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    output logic [6:0]            seg,
    output logic [IDX_W-1:0]      dig_idx,
    output logic                  led_go,
    output logic [1:0]            state,
    output logic [4*DIGITS-1:0]   score
);

    localparam int TC_W  = $clog2(TICK_DIV);
    localparam int MC_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    // Must hold DELAY_MIN + 2**DELAY_BITS - 1.
    localparam int DLY_W = $clog2(DELAY_MIN + (1 << DELAY_BITS));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_PLAY   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    typedef logic [DIGITS-1:0][3:0] digits_t;

    state_t             state_q, state_d;
    digits_t            score_q, score_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [TC_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [MC_W-1:0]    mux_cnt_q, mux_cnt_d;
    logic [IDX_W-1:0]   dig_idx_q, dig_idx_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [6:0]         seg_q, seg_d;
    logic               start_q, stop_q;

    logic               start_rise, stop_rise;
    logic               tick;
    logic               mux_last;
    digits_t            score_inc;
    logic               all_nines;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hE:    s = 7'b1000000; // dash, shown on a foul
            default: s = 7'b0000000; // blank (4'hF and unused codes)
        endcase
        return s;
    endfunction

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;
    assign tick       = (tick_cnt_q == TC_W'(TICK_DIV - 1));
    assign mux_last   = (mux_cnt_q == MC_W'(MUX_DIV - 1));

    // BCD increment with ripple carry. all_nines blocks the increment so the
    // score saturates instead of wrapping.
    always_comb begin
        logic carry;
        score_inc = score_q;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[i] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (score_q[i] == 4'd9) begin
                    score_inc[i] = 4'd0;
                end else begin
                    score_inc[i] = score_q[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        delay_d    = delay_q;
        // Fibonacci LFSR, x^8+x^6+x^5+x^4+1. It leaves 8'h01 at reset and
        // never reaches zero.
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);
        mux_cnt_d  = mux_last ? '0 : mux_cnt_q + MC_W'(1);
        dig_idx_d  = dig_idx_q;
        if (mux_last) begin
            dig_idx_d = (dig_idx_q == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
        end
        seg_d      = seg_decode(score_q[dig_idx_q]);

        case (state_q)
            S_IDLE: begin
                score_d = '1;
                if (start_rise) begin
                    state_d    = S_WAIT;
                    delay_d    = DLY_W'(DELAY_MIN)
                               + {{(DLY_W - DELAY_BITS){1'b0}}, lfsr_q[DELAY_BITS-1:0]};
                    tick_cnt_d = '0;
                end
            end
            S_WAIT: begin
                score_d = '1;
                // A foul wins over a tick that lands in the same cycle.
                if (stop_rise) begin
                    state_d = S_FINISH;
                    score_d = {DIGITS{4'hE}};
                end else if (tick) begin
                    if (delay_q == DLY_W'(1)) begin
                        state_d    = S_PLAY;
                        score_d    = '0;
                        tick_cnt_d = '0;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            S_PLAY: begin
                // A tick in the same cycle as the stop rise is not counted.
                if (stop_rise) begin
                    state_d = S_FINISH;
                end else if (tick && !all_nines) begin
                    score_d = score_inc;
                end
            end
            S_FINISH: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    score_d = '1;
                end
            end
            default: begin
                state_d = S_IDLE;
                score_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            score_q    <= '1;
            delay_q    <= '0;
            lfsr_q     <= 8'h01;
            tick_cnt_q <= '0;
            mux_cnt_q  <= '0;
            dig_idx_q  <= '0;
            seg_q      <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            delay_q    <= delay_d;
            lfsr_q     <= lfsr_d;
            tick_cnt_q <= tick_cnt_d;
            mux_cnt_q  <= mux_cnt_d;
            dig_idx_q  <= dig_idx_d;
            seg_q      <= seg_d;
            start_q    <= start;
            stop_q     <= stop;
        end
    end

    assign seg     = seg_q;
    assign dig_idx = dig_idx_q;
    assign led_go  = (state_q == S_PLAY);
    assign state   = state_q;
    assign score   = score_q;

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
//
// Directed bench for reaction_timer with DIGITS=2, TICK_DIV=4, MUX_DIV=2,
// DELAY_MIN=2 and DELAY_BITS=2. Inputs are driven 1 time unit after each posedge
// and outputs are sampled at that same point. A reference LFSR predicts the
// random delay.
// -----------------------------------------------------------------------------
module tb_reaction_timer;

  localparam int DIGITS     = 2;
  localparam int TICK_DIV   = 4;
  localparam int MUX_DIV    = 2;
  localparam int DELAY_MIN  = 2;
  localparam int DELAY_BITS = 2;

  localparam logic [6:0] SEG_0    = 7'b0000000;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] seg;
  logic [0:0] dig_idx;
  logic       led_go;
  logic [1:0] state;
  logic [7:0] score;

  int         total = 0;
  int         bad = 0;
  logic [7:0] m_lfsr;
  int         exp_delay = 0;

  reaction_timer #(
    .DIGITS     (DIGITS),
    .TICK_DIV   (TICK_DIV),
    .MUX_DIV    (MUX_DIV),
    .DELAY_MIN  (DELAY_MIN),
    .DELAY_BITS (DELAY_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .seg     (seg),
    .dig_idx (dig_idx),
    .led_go  (led_go),
    .state   (state),
    .score   (score)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Reference LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, seeded with 8'h01.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    // The DUT loads its delay from the LFSR value seen at the detecting edge.
    exp_delay = DELAY_MIN + int'(m_lfsr[DELAY_BITS-1:0]);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  // Count edges from WAIT entry until PLAY. The expected count is delay*TICK_DIV.
  task automatic wait_play(input string tag);
    int n;
    n = 0;
    while (state != 2'd2 && n < 200) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_delay * TICK_DIV));
  endtask

  // seg shows the digit selected by dig_idx one cycle earlier, so wait until
  // the previous sample of dig_idx equals idx before comparing.
  task automatic check_seg(input string tag, input logic [0:0] idx, input logic [6:0] exp);
    logic [0:0] last;
    int         n;
    bit         ok;
    last = dig_idx;
    n    = 0;
    ok   = 1'b0;
    while (n < 10 && !ok) begin
      step(1);
      n++;
      if (last == idx) ok = 1'b1;
      else             last = dig_idx;
    end
    if (ok) check_eq(tag, 32'(seg), 32'(exp));
    else    check_eq({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    step(3);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_score", 32'(score), 32'hFF);
    check_eq("rst_idx", 32'(dig_idx), 32'd0);
    check_eq("rst_seg", 32'(seg), 32'd0);
    check_eq("rst_led", 32'(led_go), 32'd0);

    // 1. Idle with no buttons
    rst_n = 1'b1;
    step(20);
    check_eq("idle_state", 32'(state), 32'd0);
    check_eq("idle_score", 32'(score), 32'hFF);
    check_eq("idle_led", 32'(led_go), 32'd0);
    check_seg("idle_seg0", 1'b0, SEG_0);
    check_seg("idle_seg1", 1'b1, SEG_0);

    // 2. Start, random wait, then PLAY
    press_start();
    check_eq("wait_state", 32'(state), 32'd1);
    check_eq("wait_score", 32'(score), 32'hFF);
    check_eq("wait_led", 32'(led_go), 32'd0);
    wait_play("wait_len1");
    check_eq("play_state", 32'(state), 32'd2);
    check_eq("play_led", 32'(led_go), 32'd1);
    check_eq("play_score0", 32'(score), 32'h00);

    // 3. 48 cycles of PLAY (12 ticks), then stop
    step(48);
    press_stop();
    check_eq("stop_state", 32'(state), 32'd3);
    check_eq("stop_score", 32'(score), 32'h12);
    check_eq("stop_led", 32'(led_go), 32'd0);
    check_seg("stop_seg0", 1'b0, SEG_2);
    check_seg("stop_seg1", 1'b1, SEG_1);

    // 4. FINISH -> IDLE, then a foul during WAIT
    press_start();
    check_eq("fin_idle_state", 32'(state), 32'd0);
    check_eq("fin_idle_score", 32'(score), 32'hFF);
    step(1);
    press_start();
    check_eq("foul_wait_state", 32'(state), 32'd1);
    step(2);
    press_stop();
    check_eq("foul_state", 32'(state), 32'd3);
    check_eq("foul_score", 32'(score), 32'hEE);
    check_eq("foul_led", 32'(led_go), 32'd0);
    check_seg("foul_seg0", 1'b0, SEG_DASH);
    check_seg("foul_seg1", 1'b1, SEG_DASH);
    step(1);
    press_start();
    check_eq("foul_idle_state", 32'(state), 32'd0);
    check_eq("foul_idle_score", 32'(score), 32'hFF);

    // 5. Long run to saturation, then both buttons together
    step(1);
    press_start();
    wait_play("wait_len2");
    step(20);
    check_eq("cnt5", 32'(score), 32'h05);
    step(20);
    check_eq("cnt10", 32'(score), 32'h10);
    step(360);
    check_eq("sat99", 32'(score), 32'h99);
    step(8);
    check_eq("sat_hold", 32'(score), 32'h99);
    check_eq("sat_state", 32'(state), 32'd2);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check_eq("both_state", 32'(state), 32'd3);
    check_eq("both_score", 32'(score), 32'h99);

    // 6. Reset mid-PLAY
    step(1);
    press_start();
    check_eq("rerun_idle", 32'(state), 32'd0);
    step(1);
    press_start();
    wait_play("wait_len3");
    step(10);
    rst_n = 1'b0;
    step(1);
    check_eq("mid_rst_state", 32'(state), 32'd0);
    check_eq("mid_rst_led", 32'(led_go), 32'd0);
    check_eq("mid_rst_score", 32'(score), 32'hFF);
    check_eq("mid_rst_idx", 32'(dig_idx), 32'd0);
    check_eq("mid_rst_seg", 32'(seg), 32'd0);
    rst_n = 1'b1;
    step(2);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
